dmem_subword: RTL and testbench
===============================

Name: dmem_subword

Overview:
- Next-generation data memory for the single-cycle/multi-cycle RISC-V core.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Adds a valid/ready request handshake, a configurable number of wait states, and error reporting for misaligned or out-of-range accesses.
- Sits between the core's load/store path and the data array; replaces the single-word, single-cycle data memory.

Parameters:
- XLEN, 32: data width in bits; fixed at 32 (4 byte lanes).
- DEPTH_WORDS, 1024: number of XLEN-bit words; power of two.
- ADDR_W, 32: width of the byte address.
- WAIT_STATES, 1: extra cycles between accept and access; legal range 0..7.
- CLEAR_ON_RESET, 1: 1 = all words cleared to 0 while reset_n is low; 0 = contents retained.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  load zero-extend (LBU/LHU); ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-aligned (low bits used for byte/half).
- rsp_valid  out  1  one-cycle response pulse, issued for loads and stores.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and on error.
- rsp_err  out  1  misaligned, illegal size or out-of-range; valid with rsp_valid.

Behaviour:
- Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0, request latch cleared.
- Reset mid-operation aborts the operation; a latched store is never written. With CLEAR_ON_RESET=1 every word reads 0 after reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/size/unsigned/addr/wdata. Go to WAIT if WAIT_STATES>0, else ACCESS.
  - WAIT: counter counts 1..WAIT_STATES, then go to ACCESS. req_ready=0.
  - ACCESS: store commits the masked byte lanes on this edge; load captures the extended data into rsp_rdata. rsp_err is computed. Go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then return to IDLE.
- Latency: request accepted at edge T gives rsp_valid high in cycle T+WAIT_STATES+2. Maximum throughput is one request per WAIT_STATES+3 cycles.
- rsp_rdata and rsp_err hold their values until the next ACCESS.
- Request inputs are ignored outside IDLE; latched values are used throughout the operation.
- Word index = addr[ADDR_W-1:2]. Byte lane = addr[1:0]. Memory is little-endian.
- Store lane masks: byte writes lane addr[1:0] with wdata[7:0]. Half writes lanes addr[1]*2 and addr[1]*2+1 with wdata[15:0]. Word writes all lanes. Unwritten lanes are unchanged.
- Load extraction: the selected byte or half is sign-extended from bit 7/15, or zero-extended when req_unsigned=1. Word loads return the full word.
- Error conditions (rsp_err=1):
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - word index >= DEPTH_WORDS.
- On error: no write occurs, rsp_rdata=0, and the response timing is unchanged.
- Back-to-back: a request held on req_valid in the RESP cycle is not accepted until IDLE, the following cycle.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - FSM state enum;
  - the XLEN/4 lane count constant.
- One combinational sub-module, dmem_lane_align:
  - store side: lane mask and shifted write data;
  - load side: lane extract and sign/zero extend;
  - misalignment flag.
- The FSM, counter and array stay in dmem_subword.

Test Plan:
- Reset then load: load word at 0x000 after reset -> rsp_rdata=0x00000000, rsp_err=0, rsp_valid exactly WAIT_STATES+2 cycles after the accept edge (3 with default).
- Sub-word stores: word store 0x11223344 @0x10; byte store 0xAA @0x11; half store 0xBEEF @0x12; then word load @0x10 -> 0xBEEFAA44.
- Sign/zero extension on that word: LB @0x11 -> 0xFFFFFFAA; LBU @0x11 -> 0x000000AA; LH @0x12 -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
- Misalignment:
  - word store 0xDEADBEEF @0x22 -> rsp_err=1;
  - then word load @0x20 -> previous contents unchanged;
  - half load @0x13 -> rsp_err=1, rsp_rdata=0;
  - size=11 -> rsp_err=1.
- Range and handshake:
  - load @ byte address 4*DEPTH_WORDS -> rsp_err=1;
  - req_valid held high continuously -> req_ready low from accept until return to IDLE; exactly one rsp_valid per request.
- Reset mid-operation: assert reset_n=0 during WAIT of a store 0x12345678 @0x40 -> no rsp_valid; after release, load @0x40 -> 0x00000000, req_ready=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and types for the sub-word data memory.
// Size encodings match the core's funct3[1:0] for loads and stores.
package dmem_pkg;

    localparam int DMEM_XLEN = 32;
    localparam int LANES     = DMEM_XLEN / 8;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store masks and data, load extraction
// with sign/zero extension, and alignment/size legality flags.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]           size,
    input  logic                 is_unsigned,
    input  logic [1:0]           lane,
    input  logic [DMEM_XLEN-1:0] wdata,
    input  logic [DMEM_XLEN-1:0] rword,
    output logic [LANES-1:0]     wmask,
    output logic [DMEM_XLEN-1:0] wdata_sh,
    output logic [DMEM_XLEN-1:0] rdata_ext,
    output logic                 misaligned,
    output logic                 size_ill
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = 8'(rword >> {lane, 3'b000});
    assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        wmask      = '0;
        wdata_sh   = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        size_ill   = 1'b0;
        case (size)
            SZ_BYTE: begin
                wmask     = LANES'(1) << lane;
                // Replicating the data puts it on every lane; the mask picks one.
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            SZ_HALF: begin
                misaligned = lane[0];
                wmask      = lane[1] ? 4'b1100 : 4'b0011;
                wdata_sh   = {2{wdata[15:0]}};
                rdata_ext  = is_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            SZ_WORD: begin
                misaligned = (lane != 2'b00);
                wmask      = '1;
                wdata_sh   = wdata;
                rdata_ext  = rword;
            end
            default: begin
                size_ill = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_subword.sv
// Data memory with byte/half/word access, valid/ready request handshake,
// programmable wait states and error reporting on illegal accesses.
//
//   state     | meaning
//   ST_IDLE   | ready for a request; latch it on accept
//   ST_WAIT   | burn WAIT_STATES cycles
//   ST_ACCESS | commit store or capture load data and error
//   ST_RESP   | one-cycle rsp_valid pulse
module dmem_subword
    import dmem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int DEPTH_WORDS    = 1024,
    parameter int ADDR_W         = 32,
    parameter int WAIT_STATES    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [2:0] WS_CNT = 3'(WAIT_STATES);

    state_e              state_q, state_d;
    logic [2:0]          cnt_q;
    logic                accept;

    logic                we_q;
    logic                uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]     wdata_q;

    logic [XLEN-1:0]     mem [DEPTH_WORDS];
    logic [IDX_W-1:0]    idx;
    logic [XLEN-1:0]     rword;

    logic [LANES-1:0]    wmask;
    logic [XLEN-1:0]     wdata_sh;
    logic [XLEN-1:0]     rdata_ext;
    logic                misaligned;
    logic                size_ill;
    logic                out_of_range;
    logic                err;
    logic                do_write;

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt_q + 3'd1 == WS_CNT) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (state_q == ST_WAIT) begin
            cnt_q <= cnt_q + 3'd1;
        end else begin
            cnt_q <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    assign idx   = addr_q[IDX_W+1:2];
    assign rword = mem[idx];

    // Depth is a power of two, so any set bit above the index field is out of range.
    if (ADDR_W > IDX_W + 2) begin : g_range
        assign out_of_range = |addr_q[ADDR_W-1:IDX_W+2];
    end else begin : g_no_range
        assign out_of_range = 1'b0;
    end

    dmem_lane_align u_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .lane        (addr_q[1:0]),
        .wdata       (wdata_q),
        .rword       (rword),
        .wmask       (wmask),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext),
        .misaligned  (misaligned),
        .size_ill    (size_ill)
    );

    assign err      = size_ill || misaligned || out_of_range;
    assign do_write = (state_q == ST_ACCESS) && we_q && !err;

    if (CLEAR_ON_RESET != 0) begin : g_mem_clr
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < DEPTH_WORDS; i++) begin
                    mem[i] <= '0;
                end
            end else if (do_write) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wmask[l]) begin
                        mem[idx][8*l +: 8] <= wdata_sh[8*l +: 8];
                    end
                end
            end
        end
    end else begin : g_mem_keep
        always_ff @(posedge clk) begin
            if (do_write) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wmask[l]) begin
                        mem[idx][8*l +: 8] <= wdata_sh[8*l +: 8];
                    end
                end
            end
        end
    end

    // Response registers only change in ACCESS and hold through later idle time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (state_q == ST_ACCESS) begin
            rsp_err   <= err;
            rsp_rdata <= (err || we_q) ? '0 : rdata_ext;
        end
    end

endmodule

// File: tb/tb_dmem_subword.sv
// Directed bench for dmem_subword: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every rsp_valid.
module tb_dmem_subword;

    localparam int WS    = 1;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    dmem_subword #(
        .XLEN           (32),
        .DEPTH_WORDS    (DEPTH),
        .ADDR_W         (32),
        .WAIT_STATES    (WS),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 want no response");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_rdata"}, rsp_rdata, e.rdata);
                check({e.name, "_err"}, 32'(rsp_err), 32'(e.err));
            end
        end
    end

    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        logic got;
        exp_t e;
        @(negedge clk);
        check({name, "_ready"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.name  = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        check({name, "_rsp_seen"}, 32'(got), 32'd1);
        check({name, "_latency"}, 32'(lat), 32'(WS + 2));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int busy;
        int rsps;
        exp_t e;
        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        reset_n = 1'b1;

        do_req("ld_w0", 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h00000000, 1'b0);

        do_req("st_w10",  1'b1, 2'b10, 1'b0, 32'h010, 32'h11223344, 32'h0, 1'b0);
        do_req("st_b11",  1'b1, 2'b00, 1'b0, 32'h011, 32'h000000AA, 32'h0, 1'b0);
        do_req("st_h12",  1'b1, 2'b01, 1'b0, 32'h012, 32'h0000BEEF, 32'h0, 1'b0);
        do_req("ld_w10",  1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hBEEFAA44, 1'b0);
        do_req("lb_11",   1'b0, 2'b00, 1'b0, 32'h011, 32'h0, 32'hFFFFFFAA, 1'b0);
        do_req("lbu_11",  1'b0, 2'b00, 1'b1, 32'h011, 32'h0, 32'h000000AA, 1'b0);
        do_req("lh_12",   1'b0, 2'b01, 1'b0, 32'h012, 32'h0, 32'hFFFFBEEF, 1'b0);
        do_req("lhu_12",  1'b0, 2'b01, 1'b1, 32'h012, 32'h0, 32'h0000BEEF, 1'b0);
        do_req("lb_10",   1'b0, 2'b00, 1'b0, 32'h010, 32'h0, 32'h00000044, 1'b0);
        do_req("lh_10",   1'b0, 2'b01, 1'b0, 32'h010, 32'h0, 32'hFFFFAA44, 1'b0);

        do_req("st_w20",   1'b1, 2'b10, 1'b0, 32'h020, 32'h55667788, 32'h0, 1'b0);
        do_req("st_w22_e", 1'b1, 2'b10, 1'b0, 32'h022, 32'hDEADBEEF, 32'h0, 1'b1);
        do_req("ld_w20",   1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h55667788, 1'b0);
        do_req("lh_13_e",  1'b0, 2'b01, 1'b0, 32'h013, 32'h0, 32'h00000000, 1'b1);
        do_req("ld_w20b",  1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h55667788, 1'b0);
        do_req("sz11_e",   1'b0, 2'b11, 1'b0, 32'h010, 32'h0, 32'h00000000, 1'b1);
        do_req("ld_oor_e", 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'h0, 32'h00000000, 1'b1);
        do_req("st_oor_e", 1'b1, 2'b10, 1'b0, 32'(4 * DEPTH + 16), 32'hCAFEF00D, 32'h0, 1'b1);
        do_req("ld_w10b",  1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'hBEEFAA44, 1'b0);

        // req_valid held high across two back-to-back operations
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h010;
        e.rdata = 32'hBEEFAA44;
        e.err   = 1'b0;
        e.name  = "hold_a";
        sb.push_back(e);
        e.name  = "hold_b";
        sb.push_back(e);
        acc  = 0;
        busy = 0;
        rsps = 0;
        for (int c = 0; c < 2 * (WS + 3); c++) begin
            if (c > 0) @(negedge clk);
            if (req_ready) acc++;
            else busy++;
            if (rsp_valid) rsps++;
            if (c == 2 * (WS + 3) - 1) req_valid = 1'b0;
        end
        check("hold_accepts", 32'(acc), 32'd2);
        check("hold_busy", 32'(busy), 32'(2 * (WS + 2)));
        check("hold_rsps", 32'(rsps), 32'd2);
        @(negedge clk);
        check("hold_idle_ready", 32'(req_ready), 32'd1);
        check("hold_no_extra", 32'(rsp_valid), 32'd0);

        // Reset during WAIT of a store
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h040;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("mid_rst_valid2", 32'(rsp_valid), 32'd0);
        reset_n = 1'b1;
        do_req("ld_w40", 1'b0, 2'b10, 1'b0, 32'h040, 32'h0, 32'h00000000, 1'b0);
        do_req("ld_w10c", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 32'h00000000, 1'b0);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
